// File: rtl/backup_ser_pkg.sv
// Shared constants and types for the backup-lane deserializer slice.
package backup_ser_pkg;

  localparam int BACKUP_DATA_WIDTH = 20;
  localparam logic [BACKUP_DATA_WIDTH-1:0] BACKUP_ALIGN_PATTERN = 20'hF0A53;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } align_state_t;

endpackage

// File: rtl/backup_align_fsm.sv
// Word-alignment FSM: watches boundary words for the idle pattern, requests slips
// while hunting and tracks lock with saturating match/miss counters.
//
// state  | meaning
// HUNT   | searching; each non-pattern word requests one slip
// VERIFY | pattern seen, counting consecutive matches toward lock
// LOCKED | aligned; counting consecutive non-pattern words toward unlock
module backup_align_fsm
  import backup_ser_pkg::*;
#(
  parameter int DATA_WIDTH = BACKUP_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ALIGN_PATTERN = BACKUP_ALIGN_PATTERN,
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_WORDS = 64
) (
  input  logic                  BackupSerClk,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  word_strobe,
  input  logic                  auto_align_en,
  output logic                  slip_req,
  output logic                  locked
);

  localparam int MATCH_W = $clog2(LOCK_COUNT) + 1;
  localparam int MISS_W  = $clog2(UNLOCK_WORDS) + 1;
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(UNLOCK_WORDS);

  align_state_t        state;
  logic                match;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  assign match = (word == ALIGN_PATTERN);

  // slip_req is a single-cycle pulse in the cycle after the offending word
  always_ff @(posedge BackupSerClk) begin
    if (clear || !auto_align_en) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      slip_req  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      slip_req <= 1'b0;
      if (word_strobe) begin
        unique case (state)
          HUNT: begin
            if (match) begin
              state     <= VERIFY;
              match_cnt <= MATCH_W'(1);
            end else begin
              slip_req <= 1'b1;
            end
          end
          VERIFY: begin
            if (match) begin
              if (match_cnt != MATCH_MAX)
                match_cnt <= match_cnt + MATCH_W'(1);
              if (match_cnt + MATCH_W'(1) >= MATCH_MAX) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              state     <= HUNT;
              match_cnt <= '0;
              slip_req  <= 1'b1;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else if (miss_cnt + MISS_W'(1) >= MISS_MAX) begin
              state     <= HUNT;
              locked    <= 1'b0;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/backup_deserializer.sv
// Backup-lane SIPO deserializer: LSB-first capture, phase counter with bit-slip,
// slip guard and registered word outputs; alignment decisions live in backup_align_fsm.
module backup_deserializer
  import backup_ser_pkg::*;
#(
  parameter int DATA_WIDTH = BACKUP_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ALIGN_PATTERN = BACKUP_ALIGN_PATTERN,
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_WORDS = 64
) (
  input  logic                  BackupSerClk,
  input  logic                  Reset,
  input  logic                  BackupEnLane,
  input  logic                  BackupSerInput,
  input  logic                  AutoAlignEn,
  input  logic                  BitSlip,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  Locked,
  output logic [4:0]            SlipCount
);

  localparam int PHASE_W = $clog2(DATA_WIDTH);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DATA_WIDTH - 1);
  localparam logic [4:0]         SLIP_LAST  = 5'(DATA_WIDTH - 1);

  logic                  clear;
  logic                  fsm_slip_req;
  logic                  slip_req;
  logic                  slip;
  logic                  boundary;
  logic                  slip_guard;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] word_next;
  logic [PHASE_W-1:0]    phase;

  assign clear     = Reset || !BackupEnLane;
  assign word_next = {BackupSerInput, shift_reg[DATA_WIDTH-1:1]};
  assign slip_req  = AutoAlignEn ? fsm_slip_req : BitSlip;
  assign slip      = slip_req && !slip_guard;
  assign boundary  = (phase == PHASE_LAST) && !slip;

  // A slip freezes the phase for one bit, pushing the word boundary one bit later
  always_ff @(posedge BackupSerClk) begin
    if (clear) begin
      shift_reg  <= '0;
      phase      <= '0;
      DataOut    <= '0;
      DataValid  <= 1'b0;
      SlipCount  <= '0;
      slip_guard <= 1'b0;
    end else begin
      shift_reg <= word_next;
      DataValid <= boundary;
      if (slip) begin
        slip_guard <= 1'b1;
        SlipCount  <= (SlipCount == SLIP_LAST) ? 5'd0 : SlipCount + 5'd1;
      end else begin
        phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
      end
      if (boundary) begin
        DataOut    <= word_next;
        slip_guard <= 1'b0;
      end
    end
  end

  backup_align_fsm #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ALIGN_PATTERN(ALIGN_PATTERN),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_WORDS (UNLOCK_WORDS)
  ) u_align_fsm (
    .BackupSerClk (BackupSerClk),
    .clear        (clear),
    .word         (word_next),
    .word_strobe  (boundary),
    .auto_align_en(AutoAlignEn),
    .slip_req     (fsm_slip_req),
    .locked       (Locked)
  );

endmodule

// File: tb/tb_backup_deserializer.sv
// Scoreboard bench for backup_deserializer: words queued as they are serialized,
// popped and compared as DataValid strobes appear.
module tb_backup_deserializer;

  localparam logic [19:0] PAT   = 20'hF0A53;
  localparam logic [19:0] NOISE = 20'h12345;

  logic        BackupSerClk   = 1'b0;
  logic        Reset          = 1'b1;
  logic        BackupEnLane   = 1'b1;
  logic        BackupSerInput = 1'b0;
  logic        AutoAlignEn    = 1'b1;
  logic        BitSlip        = 1'b0;
  logic [19:0] DataOut;
  logic        DataValid;
  logic        Locked;
  logic [4:0]  SlipCount;

  typedef struct {
    logic [19:0] data;
    logic        locked;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   sb_on    = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   dv_count = 0;

  always #5 BackupSerClk = ~BackupSerClk;

  backup_deserializer dut (
    .BackupSerClk  (BackupSerClk),
    .Reset         (Reset),
    .BackupEnLane  (BackupEnLane),
    .BackupSerInput(BackupSerInput),
    .AutoAlignEn   (AutoAlignEn),
    .BitSlip       (BitSlip),
    .DataOut       (DataOut),
    .DataValid     (DataValid),
    .Locked        (Locked),
    .SlipCount     (SlipCount)
  );

  // Output monitor, sampled just after the active edge
  always begin
    @(posedge BackupSerClk);
    #1;
    if (DataValid) begin
      dv_count++;
      if (sb_on) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_word: got DataOut=%h, no word was due", DataOut);
        end else begin
          mon_e = sb.pop_front();
          if (DataOut !== mon_e.data) begin
            failures++;
            $display("FAIL sb_data: got %h want %h", DataOut, mon_e.data);
          end
          checks++;
          if (Locked !== mon_e.locked) begin
            failures++;
            $display("FAIL sb_locked: got %b want %b (word %h)", Locked, mon_e.locked, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Caller sits at a negedge; each bit is driven then held for one clock
  task automatic send_word(input logic [19:0] w, input bit push, input logic exp_locked);
    exp_t e;
    if (push) begin
      e.data   = w;
      e.locked = exp_locked;
      sb.push_back(e);
    end
    for (int i = 0; i < 20; i++) begin
      BackupSerInput = w[i];
      @(negedge BackupSerClk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; BackupEnLane = 1'b1; AutoAlignEn = 1'b1; BitSlip = 1'b0; BackupSerInput = 1'b1;
    repeat (3) @(negedge BackupSerClk);
    checks++;
    if (DataOut !== 20'h0) begin failures++; $display("FAIL reset_dataout: got %h want 00000", DataOut); end
    checks++;
    if (DataValid !== 1'b0) begin failures++; $display("FAIL reset_datavalid: got %b want 0", DataValid); end
    checks++;
    if (Locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b want 0", Locked); end
    checks++;
    if (SlipCount !== 5'd0) begin failures++; $display("FAIL reset_slipcount: got %0d want 0", SlipCount); end
  endtask

  task automatic test_aligned_lock();
    Reset = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 6; i++) send_word(PAT, 1'b1, (i >= 3));
    checks++;
    if (SlipCount !== 5'd0) begin failures++; $display("FAIL aligned_slipcount: got %0d want 0", SlipCount); end
    checks++;
    if (Locked !== 1'b1) begin failures++; $display("FAIL aligned_locked: got %b want 1", Locked); end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 39; i++) send_word(NOISE, 1'b1, 1'b1);
    send_word(PAT, 1'b1, 1'b1);
    for (int i = 0; i < 63; i++) send_word(NOISE, 1'b1, 1'b1);
    checks++;
    if (Locked !== 1'b1) begin failures++; $display("FAIL lockloss_63: got %b want 1", Locked); end
    send_word(NOISE, 1'b1, 1'b0);
    checks++;
    if (Locked !== 1'b0) begin failures++; $display("FAIL lockloss_64: got %b want 0", Locked); end
    @(negedge BackupSerClk);
    sb_on = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL lockloss_pending: got %0d words left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_misaligned();
    int dv0;
    Reset = 1'b1;
    @(negedge BackupSerClk);
    Reset = 1'b0;
    dv0 = dv_count;
    for (int i = 0; i < 7; i++) begin
      BackupSerInput = 1'b0;
      @(negedge BackupSerClk);
    end
    for (int i = 0; i < 12; i++) send_word(PAT, 1'b0, 1'b0);
    checks++;
    if (dv_count - dv0 != 12) begin failures++; $display("FAIL misalign_strobes: got %0d want 12", dv_count - dv0); end
    checks++;
    if (SlipCount !== 5'd7) begin failures++; $display("FAIL misalign_slipcount: got %0d want 7", SlipCount); end
    checks++;
    if (Locked !== 1'b1) begin failures++; $display("FAIL misalign_locked: got %b want 1", Locked); end
    checks++;
    if (DataOut !== PAT) begin failures++; $display("FAIL misalign_dataout: got %h want %h", DataOut, PAT); end
  endtask

  task automatic test_enable_drop();
    logic [19:0] w;
    w = PAT;
    for (int i = 0; i < 10; i++) begin
      BackupSerInput = w[i];
      @(negedge BackupSerClk);
    end
    BackupEnLane = 1'b0;
    @(negedge BackupSerClk);
    checks++;
    if (DataOut !== 20'h0) begin failures++; $display("FAIL endrop_dataout: got %h want 00000", DataOut); end
    checks++;
    if (DataValid !== 1'b0) begin failures++; $display("FAIL endrop_datavalid: got %b want 0", DataValid); end
    checks++;
    if (Locked !== 1'b0) begin failures++; $display("FAIL endrop_locked: got %b want 0", Locked); end
    checks++;
    if (SlipCount !== 5'd0) begin failures++; $display("FAIL endrop_slipcount: got %0d want 0", SlipCount); end
    BackupEnLane = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 5; i++) send_word(PAT, 1'b1, (i >= 3));
    checks++;
    if (Locked !== 1'b1) begin failures++; $display("FAIL relock_locked: got %b want 1", Locked); end
    @(negedge BackupSerClk);
    sb_on = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL relock_pending: got %0d words left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid_verify();
    Reset = 1'b1;
    @(negedge BackupSerClk);
    Reset = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 2; i++) send_word(PAT, 1'b1, 1'b0);
    Reset = 1'b1;
    @(negedge BackupSerClk);
    checks++;
    if (DataOut !== 20'h0) begin failures++; $display("FAIL midreset_dataout: got %h want 00000", DataOut); end
    checks++;
    if (DataValid !== 1'b0) begin failures++; $display("FAIL midreset_datavalid: got %b want 0", DataValid); end
    checks++;
    if (Locked !== 1'b0) begin failures++; $display("FAIL midreset_locked: got %b want 0", Locked); end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) send_word(PAT, 1'b1, (i >= 3));
    @(negedge BackupSerClk);
    sb_on = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL midreset_pending: got %0d words left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_manual_slip();
    int n;
    int gap;
    int exp_gap;
    Reset = 1'b1;
    AutoAlignEn = 1'b0;
    BackupSerInput = 1'b0;
    @(negedge BackupSerClk);
    Reset = 1'b0;
    n = 0;
    while (!DataValid && n < 100) begin
      @(negedge BackupSerClk);
      n++;
    end
    checks++;
    if (!DataValid) begin
      failures++;
      $display("FAIL manual_first_strobe: got timeout want strobe within 100 cycles");
    end else begin
      BitSlip = 1'b1;
      for (int w = 0; w < 4; w++) begin
        gap = 0;
        do begin
          @(negedge BackupSerClk);
          gap++;
        end while (!DataValid && gap < 40);
        exp_gap = (w < 3) ? 21 : 20;
        checks++;
        if (gap != exp_gap) begin
          failures++;
          $display("FAIL manual_gap%0d: got %0d cycles want %0d", w, gap, exp_gap);
        end
        if (w == 2) BitSlip = 1'b0;
      end
      checks++;
      if (SlipCount !== 5'd3) begin failures++; $display("FAIL manual_slipcount: got %0d want 3", SlipCount); end
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL manual_locked: got %b want 0", Locked); end
    end
    BitSlip = 1'b0;
    AutoAlignEn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_lock_loss();
    test_misaligned();
    test_enable_drop();
    test_reset_mid_verify();
    test_manual_slip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/backup_deserializer.md
Name: backup_deserializer

Overview:
- Receive-side counterpart of the 20-bit backup PISO lane serializer. Captures one backup serial lane LSB-first in a SIPO register and recovers 20-bit word boundaries by bit-slipping.
- Alignment is automatic, against a known idle/alignment word, or manual, via BitSlip.
- Used in the DAQ/test-bench path to check backup-lane output; one instance per lane.

Parameters:
- DATA_WIDTH, 20, word width in bits; must equal the serializer's.
- ALIGN_PATTERN, 20'hF0A53, alignment/idle word the transmitter sends periodically.
- LOCK_COUNT, 4, consecutive pattern matches needed to declare lock.
- UNLOCK_WORDS, 64, consecutive non-pattern words after which lock is dropped.

Ports:
- BackupSerClk  in  1  bit-rate clock, same frequency as the transmitter's serial clock.
- Reset  in  1  synchronous, active-high reset.
- BackupEnLane  in  1  lane enable; low holds the block in its idle/cleared state.
- BackupSerInput  in  1  serial data, LSB of each word first.
- AutoAlignEn  in  1  1 = FSM drives slips; 0 = manual BitSlip drives slips.
- BitSlip  in  1  manual slip request, level-sampled.
- DataOut  out  DATA_WIDTH  recovered word.
- DataValid  out  1  one-cycle strobe per recovered word.
- Locked  out  1  alignment achieved.
- SlipCount  out  5  current bit offset, 0..DATA_WIDTH-1, wraps.

Behaviour:
- Reset=1 or BackupEnLane=0, synchronous: shift register=0, phase=0, DataOut=0, DataValid=0, Locked=0, SlipCount=0, FSM=HUNT, counters=0. Reset has priority over all other inputs.
- Shift: every enabled cycle, shift_reg <= {BackupSerInput, shift_reg[W-1:1]}.
- Phase counter: 0..W-1, increments each cycle and wraps W-1 -> 0. A boundary cycle is phase==W-1 with no slip that cycle.
- On a boundary edge:
  - DataOut <= {BackupSerInput, shift_reg[W-1:1]}.
  - DataValid=1 for exactly one cycle.
  - Latency: the last bit of a word, sampled at edge k, is visible on DataOut in cycle k+1.
- Slip: in a slip cycle the phase counter holds, so the boundary moves one bit later; shifting continues.
  - Slip has priority over a boundary; no DataValid in that cycle.
  - SlipCount increments mod W on every slip.
- Slip guard: after any slip, further slip requests are ignored until the next emitted word.
- Slip source:
  - AutoAlignEn=0: BitSlip honored, FSM held in HUNT, Locked=0.
  - AutoAlignEn=1: BitSlip ignored, FSM issues slips.
- FSM, evaluated on boundary words only:
  - HUNT: word==ALIGN_PATTERN -> VERIFY, match_cnt=1. Mismatch -> slip request, stay in HUNT. Hunting continues indefinitely; SlipCount wraps.
  - VERIFY: match -> match_cnt+1; match_cnt reaching LOCK_COUNT -> LOCKED. Mismatch -> HUNT plus slip request, match_cnt=0.
  - LOCKED: Locked=1. A pattern word clears miss_cnt; any other word increments miss_cnt; miss_cnt reaching UNLOCK_WORDS -> HUNT, Locked=0, no slip.
- Locked changes on the same edge as the DataValid that caused the transition.
- DataValid strobes at every boundary regardless of lock state; the consumer gates with Locked.
- AutoAlignEn falling while LOCKED: next cycle FSM=HUNT, Locked=0; SlipCount retained.
- Counter widths: match_cnt and miss_cnt are clog2 of LOCK_COUNT / UNLOCK_WORDS, +1; they saturate and never wrap.

Decomposition:
- Package backup_ser_pkg: BACKUP_DATA_WIDTH=20, BACKUP_ALIGN_PATTERN, align_state_t enum {HUNT, VERIFY, LOCKED}.
- Sub-module backup_align_fsm: FSM, match/miss counters and slip request. Inputs are the boundary word, a word strobe and AutoAlignEn.
- Top level holds the SIPO register, phase counter, slip guard and output registers.

Test Plan:
- Aligned lock: release Reset, stream 20'hF0A53 LSB-first starting in the first enabled cycle -> DataValid every 20 cycles, DataOut=20'hF0A53, Locked=1 on the 4th strobe, SlipCount=0.
- Misaligned lock: 7 leading zero bits, then repeated pattern -> HUNT slips once per word; final SlipCount=7; Locked=1 after 4 further matches; DataOut=20'hF0A53.
- Lock loss: after lock, send 63 words of 20'h12345 -> Locked stays 1. The 64th non-pattern word -> Locked=0 on that strobe. A pattern word inserted at word 40 restarts the count instead.
- Manual slip: AutoAlignEn=0, BitSlip held high for 3 whole words -> exactly one slip per word, SlipCount=3, Locked=0; DataValid spacing is 21 cycles across each slip.
- Enable drop: BackupEnLane=0 mid-word while LOCKED -> next cycle DataOut=0, DataValid=0, Locked=0, SlipCount=0. Re-enable plus aligned pattern -> relock per scenario 1.
- Reset mid-VERIFY (match_cnt=2): Reset for 1 cycle -> all outputs 0, FSM=HUNT; 4 fresh matches are required for lock.
